// File: rtl/recovery_redirect_unit_pkg.sv
// Shared types and helpers for the fetch-redirect producer and its lane picker.
package recovery_redirect_unit_pkg;
  localparam int ISSUE_WIDTH_D     = 2;
  localparam int PC_W              = 32;
  localparam int HIST_W            = 10;
  localparam int RAS_W             = 4;
  localparam int AGE_W             = 7;
  localparam int RECOVERY_CYCLES_D = 2;

  typedef enum logic {ST_IDLE, ST_RECOVER} rec_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [HIST_W-1:0]  hist;
    logic [2*RAS_W-1:0] ras;
    logic [AGE_W-1:0]   age;
  } redirect_info_t;

  // Distance from the ROB head; the wrap bit makes the subtraction modular.
  function automatic logic [AGE_W-1:0] rel_age(input logic [AGE_W-1:0] age,
                                               input logic [AGE_W-1:0] head);
    return age - head;
  endfunction
endpackage

// File: rtl/recovery_redirect_unit_if.sv
// Resolution/rename/interrupt inputs and redirect outputs of the recovery unit.
interface recovery_redirect_unit_if
  import recovery_redirect_unit_pkg::*;
  #(parameter int ISSUE_WIDTH = ISSUE_WIDTH_D);
  logic [AGE_W-1:0]               rob_head;
  logic [ISSUE_WIDTH-1:0]         br_valid;
  logic [ISSUE_WIDTH-1:0]         br_mispred;
  logic [ISSUE_WIDTH*AGE_W-1:0]   br_age;
  logic [ISSUE_WIDTH*PC_W-1:0]    br_target;
  logic [ISSUE_WIDTH*HIST_W-1:0]  br_hist;
  logic [ISSUE_WIDTH*2*RAS_W-1:0] br_ras;
  logic                           rn_valid;
  logic [PC_W-1:0]                rn_pc;
  logic [HIST_W-1:0]              rn_hist;
  logic [2*RAS_W-1:0]             rn_ras;
  logic                           irq_req;
  logic [PC_W-1:0]                irq_addr;
  logic                           to_recovery_phase;
  logic                           in_recovery;
  logic [PC_W-1:0]                recovered_pc;
  logic [HIST_W-1:0]              recovered_hist;
  logic [2*RAS_W-1:0]             recovered_ras;
  logic                           recover_from_rename;
  logic                           interrupt_addr_we;
  logic [PC_W-1:0]                interrupt_addr_out;
  logic                           irq_ack;
  logic [15:0]                    redirect_count;

  modport master (
    output rob_head, br_valid, br_mispred, br_age, br_target, br_hist, br_ras,
           rn_valid, rn_pc, rn_hist, rn_ras, irq_req, irq_addr,
    input  to_recovery_phase, in_recovery, recovered_pc, recovered_hist, recovered_ras,
           recover_from_rename, interrupt_addr_we, interrupt_addr_out, irq_ack, redirect_count
  );

  modport slave (
    input  rob_head, br_valid, br_mispred, br_age, br_target, br_hist, br_ras,
           rn_valid, rn_pc, rn_hist, rn_ras, irq_req, irq_addr,
    output to_recovery_phase, in_recovery, recovered_pc, recovered_hist, recovered_ras,
           recover_from_rename, interrupt_addr_we, interrupt_addr_out, irq_ack, redirect_count
  );
endinterface

// File: rtl/recovery_redirect_unit_select.sv
// Combinational picker of the oldest mispredicting lane relative to the ROB head.
module oldest_mispred_select
  import recovery_redirect_unit_pkg::*;
  #(parameter int N     = ISSUE_WIDTH_D,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1)
  (
    input  logic [AGE_W-1:0]   i_rob_head,
    input  logic [N-1:0]       i_valid,
    input  logic [N-1:0]       i_mispred,
    input  logic [N*AGE_W-1:0] i_age,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_idx,
    output logic [AGE_W-1:0]   o_age
  );
  logic [AGE_W-1:0] w_best_rel;
  logic [AGE_W-1:0] w_rel;

  always_comb begin
    o_found    = 1'b0;
    o_idx      = '0;
    o_age      = '0;
    w_best_rel = '0;
    w_rel      = '0;
    // Strict compare keeps the lower lane on a tie.
    for (int i = 0; i < N; i++) begin
      w_rel = rel_age(i_age[i*AGE_W +: AGE_W], i_rob_head);
      if (i_valid[i] && i_mispred[i] && (!o_found || (w_rel < w_best_rel))) begin
        o_found    = 1'b1;
        o_idx      = IDX_W'(i);
        o_age      = i_age[i*AGE_W +: AGE_W];
        w_best_rel = w_rel;
      end
    end
  end
endmodule

// File: rtl/recovery_redirect_unit.sv
// Redirect producer: oldest-mispredict recovery FSM, rename redirects, interrupt vector writes.
module recovery_redirect_unit
  import recovery_redirect_unit_pkg::*;
  #(parameter int ISSUE_WIDTH     = ISSUE_WIDTH_D,
    parameter int RECOVERY_CYCLES = RECOVERY_CYCLES_D)
  (
    input logic clk,
    input logic rst,
    recovery_redirect_unit_if.slave bus
  );
  localparam int IDX_W = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;
  localparam int CNT_W = (RECOVERY_CYCLES > 1) ? $clog2(RECOVERY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(RECOVERY_CYCLES - 1);

  rec_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  redirect_info_t   r_info, w_info_nxt, w_cand;
  logic             r_age_vld, w_age_vld_nxt;
  logic             r_to_rec, w_to_rec_nxt;
  logic             r_rename, w_rename_nxt;
  logic             r_irq_we, w_irq_we_nxt;
  logic [PC_W-1:0]  r_irq_addr, w_irq_addr_nxt;
  logic [15:0]      r_count;
  logic             w_found, w_older, w_pulse;
  logic [IDX_W-1:0] w_idx;
  logic [AGE_W-1:0] w_sel_age;

  oldest_mispred_select #(.N(ISSUE_WIDTH)) u_select (
    .i_rob_head (bus.rob_head),
    .i_valid    (bus.br_valid),
    .i_mispred  (bus.br_mispred),
    .i_age      (bus.br_age),
    .o_found    (w_found),
    .o_idx      (w_idx),
    .o_age      (w_sel_age)
  );

  always_comb begin
    w_cand.pc   = bus.br_target[int'(w_idx)*PC_W +: PC_W];
    w_cand.hist = bus.br_hist[int'(w_idx)*HIST_W +: HIST_W];
    w_cand.ras  = bus.br_ras[int'(w_idx)*2*RAS_W +: 2*RAS_W];
    w_cand.age  = w_sel_age;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_info_nxt     = r_info;
    w_age_vld_nxt  = r_age_vld;
    w_to_rec_nxt   = 1'b0;
    w_rename_nxt   = 1'b0;
    w_irq_we_nxt   = 1'b0;
    w_irq_addr_nxt = r_irq_addr;
    w_older        = !r_age_vld ||
                     (rel_age(w_sel_age, bus.rob_head) < rel_age(r_info.age, bus.rob_head));
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_info_nxt    = w_cand;
          w_age_vld_nxt = 1'b1;
          w_to_rec_nxt  = 1'b1;
          w_cnt_nxt     = CNT_RELOAD;
          w_state_nxt   = ST_RECOVER;
        end else if (bus.rn_valid) begin
          w_info_nxt.pc   = bus.rn_pc;
          w_info_nxt.hist = bus.rn_hist;
          w_info_nxt.ras  = bus.rn_ras;
          w_rename_nxt    = 1'b1;
        end else if (bus.irq_req && !r_irq_we) begin
          // Requester still holds irq_req during the ack cycle; do not re-deliver.
          w_irq_we_nxt   = 1'b1;
          w_irq_addr_nxt = bus.irq_addr;
        end
      end
      ST_RECOVER: begin
        if (w_found && w_older) begin
          w_info_nxt    = w_cand;
          w_age_vld_nxt = 1'b1;
          w_to_rec_nxt  = 1'b1;
          w_cnt_nxt     = CNT_RELOAD;
        end else if (r_cnt == '0) begin
          w_state_nxt   = ST_IDLE;
          w_age_vld_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_info     <= '0;
      r_age_vld  <= 1'b0;
      r_to_rec   <= 1'b0;
      r_rename   <= 1'b0;
      r_irq_we   <= 1'b0;
      r_irq_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_info     <= w_info_nxt;
      r_age_vld  <= w_age_vld_nxt;
      r_to_rec   <= w_to_rec_nxt;
      r_rename   <= w_rename_nxt;
      r_irq_we   <= w_irq_we_nxt;
      r_irq_addr <= w_irq_addr_nxt;
    end
  end

  assign w_pulse = r_to_rec | r_rename | r_irq_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_pulse && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign bus.to_recovery_phase   = r_to_rec;
  assign bus.in_recovery         = (r_state == ST_RECOVER);
  assign bus.recovered_pc        = r_info.pc;
  assign bus.recovered_hist      = r_info.hist;
  assign bus.recovered_ras       = r_info.ras;
  assign bus.recover_from_rename = r_rename;
  assign bus.interrupt_addr_we   = r_irq_we;
  assign bus.irq_ack             = r_irq_we;
  assign bus.interrupt_addr_out  = r_irq_addr;
  assign bus.redirect_count      = r_count;
endmodule

// File: doc/recovery_redirect_unit.md
Name: recovery_redirect_unit

Overview:
- Producer side of the fetch-redirect interface consumed by the next-PC stage.
- Collects branch-resolution results from the integer issue lanes, rename-stage mispredict reports and interrupt requests.
- Selects the oldest mispredict by ROB age and sequences a recovery-phase FSM.
- Drives registered redirects: recovery phase, recovered PC, branch history and RAS checkpoint, rename redirect, interrupt address write.

Parameters:
ISSUE_WIDTH, 2, number of branch-resolution lanes
PC_WIDTH, 32, PC width
HIST_WIDTH, 10, global branch history width
RAS_PTR_WIDTH, 4, RAS stack-top/queue-tail pointer width
AGE_WIDTH, 7, ROB index width including wrap bit
RECOVERY_CYCLES, 2, cycles the recovery phase is held, minimum 1

Ports:
clk in 1 clock
rst in 1 asynchronous active-low reset
rob_head in AGE_WIDTH ROB head index, reference for age comparison
br_valid in ISSUE_WIDTH per-lane resolution valid
br_mispred in ISSUE_WIDTH per-lane mispredict flag
br_age in ISSUE_WIDTH*AGE_WIDTH per-lane ROB index
br_target in ISSUE_WIDTH*PC_WIDTH per-lane correct next PC
br_hist in ISSUE_WIDTH*HIST_WIDTH per-lane recovered history
br_ras in ISSUE_WIDTH*2*RAS_PTR_WIDTH per-lane {stackTop, queueTail}
rn_valid in 1 rename-stage mispredict
rn_pc in PC_WIDTH rename redirect PC
rn_hist in HIST_WIDTH rename history
rn_ras in 2*RAS_PTR_WIDTH rename RAS checkpoint
irq_req in 1 interrupt request (level, held until irq_ack)
irq_addr in PC_WIDTH interrupt vector
to_recovery_phase out 1 one-cycle pulse at start of recovery
in_recovery out 1 recovery phase active
recovered_pc out PC_WIDTH redirect PC
recovered_hist out HIST_WIDTH redirect history
recovered_ras out 2*RAS_PTR_WIDTH redirect RAS checkpoint
recover_from_rename out 1 one-cycle rename redirect
interrupt_addr_we out 1 one-cycle interrupt PC write
interrupt_addr_out out PC_WIDTH interrupt PC
irq_ack out 1 equals interrupt_addr_we
redirect_count out 16 saturating count of redirects issued

Behaviour:
- Reset, asynchronous, active when rst=0: FSM IDLE; counter 0; all outputs 0; pending age invalid.
- Age: relative age = (br_age - rob_head) mod 2^AGE_WIDTH. Smaller relative age is older. On a tie, the lower lane index wins.
- Candidate: lane with br_valid & br_mispred and the smallest relative age.
- FSM states IDLE, RECOVER.
- IDLE:
  - Candidate in cycle N: latch target/hist/ras/age. In cycle N+1: to_recovery_phase=1, in_recovery=1, state RECOVER, counter=RECOVERY_CYCLES-1.
  - No candidate and rn_valid: latch the rename values. In cycle N+1: recover_from_rename=1 for one cycle, state stays IDLE.
- RECOVER:
  - in_recovery=1 and the counter decrements each cycle. When it is 0 and there is no restart, return to IDLE and deassert in_recovery next cycle.
  - A candidate strictly older than the latched age restarts recovery: relatch, pulse to_recovery_phase again next cycle, reload the counter.
  - Younger or equal candidates are dropped.
  - rn_valid is ignored.
- Priority in one cycle: mispredict > rename > interrupt.
  - A rename report in the same cycle as a candidate is dropped.
- Interrupt:
  - Delivered only in IDLE, with no candidate and no rn_valid that cycle.
  - interrupt_addr_we=1 and irq_ack=1 in the next cycle, with interrupt_addr_out=irq_addr.
  - The requester drops irq_req after irq_ack. The unit does not re-deliver while irq_ack is high.
- recovered_pc/hist/ras hold the last latched values between redirects. Values are valid only while to_recovery_phase or recover_from_rename is 1.
- redirect_count increments on each to_recovery_phase, recover_from_rename or interrupt_addr_we pulse, and saturates at 0xFFFF.
- Output pulses are mutually exclusive in any cycle.
- Reset asserted mid-recovery aborts immediately; no pulse is emitted after release.

Decomposition:
- Shared package: FSM state enum; RedirectInfo struct {pc, hist, ras, age}; relative-age function; RECOVERY_CYCLES default.
- Sub-module oldest_mispred_select: combinational oldest-lane picker over ISSUE_WIDTH lanes, reusable by the commit stage.

Test Plan:
- Reset release, idle inputs -> all outputs 0 for 10 cycles, redirect_count=0.
- rob_head=120, lane0 age=5 target 0x1000, lane1 age=125 target 0x2000, both mispredict in cycle N -> cycle N+1: to_recovery_phase=1, recovered_pc=0x2000 (wrap case, lane1 older); in_recovery high for exactly 2 cycles.
- During RECOVER: older mispredict (rel age 3 vs latched 10, target 0x3000) -> second pulse, recovered_pc=0x3000, in_recovery extended 2 cycles; younger mispredict -> no pulse.
- rn_valid with rn_pc=0x400 and lane0 mispredict in the same cycle -> only to_recovery_phase; later rn_valid alone in IDLE -> recover_from_rename=1 with recovered_pc=0x400.
- irq_req with irq_addr=0x8000 during RECOVER -> no delivery until IDLE, then interrupt_addr_we=irq_ack=1 for one cycle with 0x8000.
- rst low in the middle of RECOVER -> outputs 0 asynchronously; after release no pulse is emitted and the count stays 0.
